windowed_reg_file: RTL

WINDOWED_REG_FILE -- requirements
Module: windowed_reg_file

---
 rtl/windowed_reg_file_pkg.sv | 20 ++
 rtl/windowed_reg_file_addr_map.sv | 38 +++
 rtl/windowed_reg_file.sv | 125 ++++++++++++
 3 files changed

// File: rtl/windowed_reg_file_pkg.sv
// Shared constants and types for the windowed register file.
// Architectural address bases and the registered trap cause.
package windowed_reg_file_pkg;

    localparam int unsigned REG_BITS    = 5;
    localparam int unsigned NUM_GLOBALS = 8;
    localparam int unsigned WIN_REGS    = 16;

    localparam int unsigned GLOBAL_BASE = 0;
    localparam int unsigned OUT_BASE    = 8;
    localparam int unsigned LOCAL_BASE  = 16;
    localparam int unsigned IN_BASE     = 24;

    typedef enum logic [1:0] {
        TrapNone,
        TrapOvf,
        TrapUnf
    } trap_e;

endpackage

// File: rtl/windowed_reg_file_addr_map.sv
// Maps an architectural register address plus window pointer to a physical index.
// Physical layout: globals at 0..7, then 16 registers per window.
module win_addr_map #(
    parameter int unsigned NWINDOWS = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned CWP_W    = $clog2(NWINDOWS),
    parameter int unsigned IDX_W    = $clog2(8 + 16 * NWINDOWS)
) (
    input  logic [ADDR_W-1:0] reg_i,
    input  logic [CWP_W-1:0]  cwp_i,
    output logic [IDX_W-1:0]  idx_o
);
    import windowed_reg_file_pkg::*;

    int unsigned r;
    int unsigned w;
    int unsigned nxt;
    int unsigned phys;

    always_comb begin
        r    = 32'(reg_i);
        w    = 32'(cwp_i);
        nxt  = (w == NWINDOWS - 1) ? 0 : w + 1;
        phys = 0;
        if (r < OUT_BASE) begin
            phys = r - GLOBAL_BASE;
        end else if (r < LOCAL_BASE) begin
            phys = NUM_GLOBALS + w * WIN_REGS + (r - OUT_BASE);
        end else if (r < IN_BASE) begin
            phys = NUM_GLOBALS + w * WIN_REGS + 8 + (r - LOCAL_BASE);
        end else begin
            // Ins are the outs of the next window up.
            phys = NUM_GLOBALS + nxt * WIN_REGS + (r - IN_BASE);
        end
        idx_o = IDX_W'(phys);
    end

endmodule

// File: rtl/windowed_reg_file.sv
// SPARC-style windowed register file: globals plus overlapping register windows,
// registered reads with write-first bypass, save/restore with WIM-checked traps.
module windowed_reg_file #(
    parameter int unsigned       NWINDOWS  = 8,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       REG_BITS  = windowed_reg_file_pkg::REG_BITS,
    parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(32'hFFFF_FFFF)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [REG_BITS-1:0]         rs1,
    input  logic [REG_BITS-1:0]         rs2,
    output logic [DATA_W-1:0]           rd1_data,
    output logic [DATA_W-1:0]           rd2_data,
    input  logic                        wr_en,
    input  logic [REG_BITS-1:0]         rd,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        save,
    input  logic                        restore,
    input  logic                        wim_we,
    input  logic [NWINDOWS-1:0]         wim_wdata,
    output logic [$clog2(NWINDOWS)-1:0] cwp,
    output logic [NWINDOWS-1:0]         wim,
    output logic                        trap_ovf,
    output logic                        trap_unf
);
    import windowed_reg_file_pkg::*;

    localparam int unsigned CWP_W = $clog2(NWINDOWS);
    localparam int unsigned NPHYS = NUM_GLOBALS + WIN_REGS * NWINDOWS;
    localparam int unsigned IDX_W = $clog2(NPHYS);
    localparam logic [NWINDOWS-1:0] WIM_RST = {1'b1, {(NWINDOWS - 1){1'b0}}};
    localparam logic [CWP_W-1:0]    CWP_MAX = CWP_W'(NWINDOWS - 1);

    logic [DATA_W-1:0] regs_q [NPHYS];
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic [CWP_W-1:0]  cwp_q, cwp_d, save_tgt, rest_tgt;
    logic [NWINDOWS-1:0] wim_q, wim_d;
    trap_e             trap_q, trap_d;
    logic [IDX_W-1:0]  rs1_idx, rs2_idx, wr_idx;
    logic              wr_ok;

    win_addr_map #(.NWINDOWS(NWINDOWS), .ADDR_W(REG_BITS)) u_map_rs1 (
        .reg_i(rs1), .cwp_i(cwp_q), .idx_o(rs1_idx)
    );
    win_addr_map #(.NWINDOWS(NWINDOWS), .ADDR_W(REG_BITS)) u_map_rs2 (
        .reg_i(rs2), .cwp_i(cwp_q), .idx_o(rs2_idx)
    );
    win_addr_map #(.NWINDOWS(NWINDOWS), .ADDR_W(REG_BITS)) u_map_rd (
        .reg_i(rd), .cwp_i(cwp_q), .idx_o(wr_idx)
    );

    // Physical index 0 is g0 only, so this also discards writes to r0.
    assign wr_ok = wr_en && (wr_idx != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPHYS; i++) begin
                regs_q[i] <= (i == 0) ? '0 : RESET_VAL;
            end
        end else if (wr_ok) begin
            regs_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd1_d = regs_q[rs1_idx];
        rd2_d = regs_q[rs2_idx];
        if (wr_ok && (wr_idx == rs1_idx)) rd1_d = wr_data;
        if (wr_ok && (wr_idx == rs2_idx)) rd2_d = wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    // Window control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cwp_q  <= '0;
            wim_q  <= WIM_RST;
            trap_q <= TrapNone;
        end else begin
            cwp_q  <= cwp_d;
            wim_q  <= wim_d;
            trap_q <= trap_d;
        end
    end

    // Targets are checked against the pre-edge WIM, even when it is being rewritten.
    always_comb begin
        save_tgt = (cwp_q == '0) ? CWP_MAX : cwp_q - CWP_W'(1);
        rest_tgt = (cwp_q == CWP_MAX) ? '0 : cwp_q + CWP_W'(1);
        cwp_d    = cwp_q;
        trap_d   = TrapNone;
        wim_d    = wim_we ? wim_wdata : wim_q;
        case ({save, restore})
            2'b10: begin
                if (wim_q[save_tgt]) trap_d = TrapOvf;
                else                 cwp_d  = save_tgt;
            end
            2'b01: begin
                if (wim_q[rest_tgt]) trap_d = TrapUnf;
                else                 cwp_d  = rest_tgt;
            end
            default: ;
        endcase
    end

    always_comb begin
        cwp      = cwp_q;
        wim      = wim_q;
        trap_ovf = (trap_q == TrapOvf);
        trap_unf = (trap_q == TrapUnf);
        rd1_data = rd1_q;
        rd2_data = rd2_q;
    end

endmodule
